// File: rtl/mul_pkg.sv
// Shared widths and the output FIFO entry layout for the pipelined multiply unit.
package mul_pkg;

    localparam int DW        = 16;
    localparam int TAGW      = 4;
    localparam int PW        = 2 * DW;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [PW-1:0]   result;
        logic [TAGW-1:0] tag;
        logic            hi_nz;
    } fifo_entry_t;

endpackage

// File: rtl/WalMul.sv
// Combinational 16x16 unsigned multiplier: carry-save reduction of the
// partial-product rows followed by a single carry-propagate add.
module WalMul (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [32:0] P
);

    logic [32:0] pp    [16];
    logic [32:0] sum_w [15];
    logic [32:0] car_w [15];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pp
            assign pp[gi] = B[gi] ? ({17'b0, A} << gi) : 33'b0;
        end
    endgenerate

    assign sum_w[0] = pp[0];
    assign car_w[0] = pp[1];

    // Each 3:2 stage folds one more partial-product row into the sum/carry pair.
    generate
        for (genvar gi = 1; gi < 15; gi++) begin : g_csa
            assign sum_w[gi] = sum_w[gi-1] ^ car_w[gi-1] ^ pp[gi+1];
            assign car_w[gi] = ((sum_w[gi-1] & car_w[gi-1]) |
                                (sum_w[gi-1] & pp[gi+1])    |
                                (car_w[gi-1] & pp[gi+1])) << 1;
        end
    endgenerate

    assign P = sum_w[14] + car_w[14];

endmodule

// File: rtl/mul_out_fifo.sv
// Result buffer between the multiply pipeline and the writeback bus; the head
// entry is presented directly from the storage array at the read pointer.
module mul_out_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output logic        empty,
    output fifo_entry_t head
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    fifo_entry_t     mem_reg [DEPTH];
    logic [PTRW-1:0] wr_ptr_reg;
    logic [PTRW-1:0] rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push_en;
    logic            pop_en;
    logic            kill;

    assign kill    = rst | flush;
    assign empty   = (count_reg == '0);
    assign push_en = push & ~kill;
    assign pop_en  = pop & ~empty & ~kill;
    assign head    = mem_reg[rd_ptr_reg];

    // Entries are cleared only by reset so the head reads zero out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_en && (wr_ptr_reg == PTRW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (kill) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Pipelined multiply functional unit: operand registers, WalMul, product
// registers and an output FIFO, with credit-based issue so the pipe never stalls.
module mul_unit
    import mul_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [DW-1:0]   issue_a,
    input  logic [DW-1:0]   issue_b,
    input  logic [TAGW-1:0] issue_tag,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [PW-1:0]   wb_result,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_hi_nz,
    output logic            busy
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic            s1_v_reg;
    logic [DW-1:0]   s1_a_reg;
    logic [DW-1:0]   s1_b_reg;
    logic [TAGW-1:0] s1_tag_reg;
    logic            s2_v_reg;
    logic [PW-1:0]   s2_p_reg;
    logic [TAGW-1:0] s2_tag_reg;
    logic            s2_hi_reg;
    logic [CW-1:0]   inflight_reg;

    logic [PW:0]     prod;
    logic            kill;
    logic            issue_fire;
    logic            wb_fire;
    logic            fifo_empty;
    fifo_entry_t     fifo_in;
    fifo_entry_t     fifo_head;

    assign kill        = rst | flush;
    assign issue_ready = (inflight_reg < DEPTH_CNT) & ~kill;
    assign issue_fire  = issue_valid & issue_ready;
    assign wb_valid    = ~fifo_empty;
    assign wb_fire     = wb_valid & wb_ready;
    assign busy        = (inflight_reg != '0);

    always_ff @(posedge clk) begin
        if (kill) begin
            s1_v_reg <= 1'b0;
        end else begin
            s1_v_reg <= issue_fire;
        end
        if (issue_fire) begin
            s1_a_reg   <= issue_a;
            s1_b_reg   <= issue_b;
            s1_tag_reg <= issue_tag;
        end
    end

    WalMul u_walmul (
        .A (s1_a_reg),
        .B (s1_b_reg),
        .P (prod)
    );

    // prod[PW] is always zero for unsigned operands, so folding it into the
    // overflow flag costs nothing and keeps the bit accounted for.
    always_ff @(posedge clk) begin
        if (kill) begin
            s2_v_reg <= 1'b0;
        end else begin
            s2_v_reg <= s1_v_reg;
        end
        s2_p_reg   <= prod[PW-1:0];
        s2_tag_reg <= s1_tag_reg;
        s2_hi_reg  <= |prod[PW:DW];
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            inflight_reg <= '0;
        end else begin
            case ({issue_fire, wb_fire})
                2'b10:   inflight_reg <= inflight_reg + CW'(1);
                2'b01:   inflight_reg <= inflight_reg - CW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    assign fifo_in = '{result: s2_p_reg, tag: s2_tag_reg, hi_nz: s2_hi_reg};

    mul_out_fifo #(
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (s2_v_reg),
        .push_data (fifo_in),
        .pop       (wb_fire),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign wb_result = fifo_head.result;
    assign wb_tag    = fifo_head.tag;
    assign wb_hi_nz  = fifo_head.hi_nz;

endmodule
